// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the shared register-file write port.
// Round-robin grant among NUM_REQ requesters, one registered write per cycle,
// plus a per-register pending-write scoreboard for issue-stage hazard checks.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic [(1<<ADDR_W)-1:0]    busy_vec
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [PTR_W-1:0]   r_rr_ptr;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [DATA_W-1:0]  r_wdata;
  logic [NREG-1:0]    r_busy;

  int                 w_idx;
  logic               w_any;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_issue_fire;
  logic [NREG-1:0]    w_busy_nxt;

  // Rotating search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    w_idx     = 0;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_any && req_valid[w_idx]) begin
        w_any          = 1'b1;
        w_gnt_idx      = PTR_W'(w_idx);
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt  = (w_gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + PTR_W'(1);
  assign w_sel_addr = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_sel_data = req_data[w_gnt_idx*DATA_W +: DATA_W];

  // Scoreboard update: writeback clears first, a new issue to the same register wins.
  assign w_issue_fire = issue_valid & ~r_busy[issue_addr];
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we)         w_busy_nxt[r_waddr]    = 1'b0;
    if (w_issue_fire) w_busy_nxt[issue_addr] = 1'b1;
  end

  // Register the winning write and advance the round-robin pointer past the winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= w_any;
      if (w_any) begin
        r_rr_ptr <= w_ptr_nxt;
        r_waddr  <= w_sel_addr;
        r_wdata  <= w_sel_data;
      end
    end
  end

  // Pending-write scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign req_ready   = w_grant;
  assign rf_we       = r_we;
  assign rf_waddr    = r_waddr;
  assign rf_wdata    = r_wdata;
  assign issue_ready = ~r_busy[issue_addr];
  assign hazard1     = r_busy[rd_addr1];
  assign hazard2     = r_busy[rd_addr2];
  assign busy_vec    = r_busy;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 8 x 19-bit register file among NUM_REQ writeback requesters (ALU, load unit, move/immediate unit) using round-robin valid/ready arbitration. The block registers the winning request onto the register-file write port. It also keeps a per-register pending-write scoreboard, which the issue stage uses for RAW/WAW hazard checks against read ports r1/r2. It sits between the execution units and the register file, beside the decode/issue logic.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..4)
DATA_W, 19, register data width
ADDR_W, 3, register index width (2**ADDR_W registers)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
req_valid  input  NUM_REQ  requester i has a write pending
req_addr  input  NUM_REQ*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  data of requester i, slice [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] && req_ready[i]
rf_we  output  1  to register_write
rf_waddr  output  ADDR_W  to write address r3
rf_wdata  output  DATA_W  to write_data
issue_valid  input  1  issue stage is dispatching an instruction that writes issue_addr
issue_addr  input  ADDR_W  destination of the issuing instruction
issue_ready  output  1  low if issue_addr already has a pending write (WAW stall)
rd_addr1  input  ADDR_W  issue-stage source 1 (mirrors r1)
rd_addr2  input  ADDR_W  issue-stage source 2 (mirrors r2)
hazard1  output  1  rd_addr1 has a pending write
hazard2  output  1  rd_addr2 has a pending write
busy_vec  output  2**ADDR_W  scoreboard, bit k = register k pending

Behaviour:
- Reset (async): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, rr_ptr=0. All outputs derived from these are 0, except issue_ready=1. An accepted write still in the output register is discarded; its scoreboard bit is cleared.
- Arbitration is combinational from req_valid and rr_ptr. Search starts at index rr_ptr and wraps modulo NUM_REQ. The first valid index gets req_ready. At most one req_ready bit is high. With no valid requests, req_ready=0.
- On acceptance of i: rr_ptr <= (i+1) mod NUM_REQ. rr_ptr holds when nothing is granted.
- req_ready does not depend on rf_we. The port accepts one write per cycle with no backpressure beyond arbitration.
- Latency: a request accepted in cycle N drives rf_we=1, rf_waddr and rf_wdata in cycle N+1. The register file commits at the end of N+1. With no acceptance in N, rf_we=0 in N+1 and rf_waddr/rf_wdata hold their values.
- Requesters must hold addr/data stable while valid && !ready. A requester may drop valid without being granted.
- Scoreboard set: at an edge where issue_valid && issue_ready, busy[issue_addr] <= 1.
- Scoreboard clear: at an edge where rf_we=1, busy[rf_waddr] <= 0.
- Same register set and cleared at one edge: set wins, so the bit stays 1 for the new writer.
- issue_ready = ~busy[issue_addr], combinational.
- hazard1 = busy[rd_addr1] and hazard2 = busy[rd_addr2], combinational. They stay high through the rf_we cycle, because the combinational read returns the new value only after that edge.
- A writeback to a non-busy register (protocol violation) is still written. The clear has no effect.
- Requester i mapping: index 0 = ALU, 1 = load, 2 = move/immediate. Fairness is purely round-robin, with no fixed priority.

Test Plan:
- Reset: assert reset mid-stream with rf_we=1 -> rf_we=0, busy_vec=8'h00, issue_ready=1, hazard1/2=0, without waiting for a clock edge.
- Single write: issue_valid with issue_addr=5 -> busy_vec=8'h20 and hazard1=1 for rd_addr1=5. Then req_valid=3'b001, addr 5, data 19'h1ABCD -> req_ready=001 in cycle N; in N+1 rf_we=1, waddr=5, wdata=19'h1ABCD. After the N+1 edge, busy_vec=0 and the register file reads 19'h1ABCD at r1=5.
- Round-robin: all three valid continuously from rr_ptr=0 -> grants 0,1,2,0,1,2 on consecutive cycles. With only 0 and 2 valid and rr_ptr=1 -> grant 2, then 0.
- WAW stall: busy[3]=1 and issue_valid with addr 3 -> issue_ready=0 and busy unchanged. Same cycle as rf_we for addr 3 -> issue_ready=0; the next cycle issue_ready=1.
- Set/clear collision: rf_we=1, waddr=4 while issue_valid, issue_addr=4 and busy[4]=0 (violation path) -> after the edge busy[4]=1.
- Hold and wrap: requester 1 valid with ready low for 3 cycles under contention -> data is sampled only in the grant cycle. rr_ptr wraps from 2 to 0 correctly.
